// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - core-wide fetch constants, state encodings and IF/ID bundle layout
package instr_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] IFU_NOP_INSTR  = 32'h0000_0013;
  localparam int          IFU_IMEM_WORDS = 1024;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Decode consumes the IF/ID register in this layout.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_unit_if_id.sv
// rtl/instr_fetch_unit_if_id.sv - IF/ID pipeline register with load enable and flush to bubble
module if_id_pipe_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = IFU_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc4
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_pc4;

  // Flush outranks load so a redirect never lets the wrong-path word through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_en) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, boot/run/fault FSM, window check, IF/ID capture
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int                    IMEM_WORDS = IFU_IMEM_WORDS,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = IFU_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rd,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  ifid_valid_o,
  output logic [DATA_WIDTH-1:0] ifid_instr_o,
  output logic [DATA_WIDTH-1:0] ifid_pc_o,
  output logic [DATA_WIDTH-1:0] ifid_pc4_o,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] fault_pc_o,
  output logic [31:0]           fetch_count_o
);

  localparam logic [DATA_WIDTH-1:0] WIN_BYTES = DATA_WIDTH'(IMEM_WORDS * 4);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fault_pc;
  logic [31:0]           r_count;

  logic [DATA_WIDTH-1:0] w_pc4;
  logic                  w_tgt_ok;
  logic                  w_pc4_ok;
  logic                  w_run;
  logic                  w_capture;
  logic                  w_flush;

  // Offsets below the base wrap to huge values, so one unsigned compare covers both ends.
  assign w_pc4     = r_pc + DATA_WIDTH'(4);
  assign w_tgt_ok  = (redirect_pc_i[1:0] == 2'b00) && ((redirect_pc_i - RESET_PC) < WIN_BYTES);
  assign w_pc4_ok  = (w_pc4 - RESET_PC) < WIN_BYTES;
  assign w_run     = (r_state == ST_RUN);
  assign w_capture = w_run && !redirect_i && !stall_i;
  assign w_flush   = (w_run && redirect_i) || (r_state == ST_FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (redirect_i) begin
            if (w_tgt_ok) begin
              r_pc <= redirect_pc_i;
            end else begin
              r_state    <= ST_FAULT;
              r_fault_pc <= redirect_pc_i;
            end
          end else if (!stall_i) begin
            r_pc    <= w_pc4;
            r_count <= r_count + 32'd1;
            if (!w_pc4_ok) begin
              r_state    <= ST_FAULT;
              r_fault_pc <= w_pc4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  if_id_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_capture),
    .i_flush (w_flush),
    .i_instr (imem_rd),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .o_valid (ifid_valid_o),
    .o_instr (ifid_instr_o),
    .o_pc    (ifid_pc_o),
    .o_pc4   (ifid_pc4_o)
  );

  assign imem_addr     = r_pc;
  assign fault_o       = (r_state == ST_FAULT);
  assign fault_pc_o    = r_fault_pc;
  assign fetch_count_o = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SPAN = 32'd4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o, ifid_pc_o, ifid_pc4_o;
  logic        fault_o;
  logic [31:0] fault_pc_o, fetch_count_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];

  typedef enum {M_BOOT, M_RUN, M_FAULT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fpc, m_count;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < SPAN) return mem[off[11:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb imem_rd = mem_word(imem_addr);

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o),
    .fetch_count_o (fetch_count_o)
  );

  // Reference: apply one clock of the fetch rules to the abstract machine state.
  task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] t);
    logic [31:0] nxt;
    if (r) begin
      m_mode = M_BOOT; m_pc = BASE; m_valid = 0; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0;
      m_fault = 0; m_fpc = 0; m_count = 0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (rd) begin
        m_valid = 0; m_instr = NOP;
        if (t[1:0] != 2'b00 || (t - BASE) >= SPAN) begin
          m_mode = M_FAULT; m_fault = 1; m_fpc = t;
        end else m_pc = t;
      end else if (!s) begin
        nxt = m_pc + 32'd4;
        m_valid = 1; m_instr = mem_word(m_pc); m_ifpc = m_pc; m_ifpc4 = nxt;
        m_count = m_count + 1; m_pc = nxt;
        if ((nxt - BASE) >= SPAN) begin m_mode = M_FAULT; m_fault = 1; m_fpc = nxt; end
      end
    end else begin
      m_valid = 0; m_instr = NOP;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall_i = s; redirect_i = rd; redirect_pc_i = t;
    model_edge(r, s, rd, t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    tests++; if (imem_addr !== BASE) begin fails++; $display("FAIL %s imem_addr got %h want %h", tag, imem_addr, BASE); end
    tests++; if (ifid_valid_o !== 1'b0) begin fails++; $display("FAIL %s valid got %b want 0", tag, ifid_valid_o); end
    tests++; if (ifid_instr_o !== NOP) begin fails++; $display("FAIL %s instr got %h want %h", tag, ifid_instr_o, NOP); end
    tests++; if (ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin fails++; $display("FAIL %s ifid_pc got %h/%h want 0/0", tag, ifid_pc_o, ifid_pc4_o); end
    tests++; if (fault_o !== 1'b0 || fault_pc_o !== 32'h0) begin fails++; $display("FAIL %s fault got %b/%h want 0/0", tag, fault_o, fault_pc_o); end
    tests++; if (fetch_count_o !== 32'h0) begin fails++; $display("FAIL %s count got %0d want 0", tag, fetch_count_o); end
  endtask

  task automatic test_boot_fetch;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_valid_o !== 1'b0 || imem_addr !== BASE) begin fails++; $display("FAIL boot got valid %b addr %h want 0 %h", ifid_valid_o, imem_addr, BASE); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if ({ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o} !== {1'b1, 32'h0050_0093, 32'h0040_0000, 32'h0040_0004}) begin
      fails++; $display("FAIL first_fetch got %b %h %h %h want 1 00500093 00400000 00400004", ifid_valid_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_instr_o !== 32'h0010_0113 || ifid_pc_o !== 32'h0040_0004) begin fails++; $display("FAIL second_fetch got %h %h want 00100113 00400004", ifid_instr_o, ifid_pc_o); end
    tests++; if (fetch_count_o !== 32'd2) begin fails++; $display("FAIL boot_count got %0d want 2", fetch_count_o); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      tests++; if (imem_addr !== 32'h0040_0008 || ifid_instr_o !== 32'h0010_0113 || fetch_count_o !== 32'd2) begin
        fails++; $display("FAIL stall_hold got %h %h %0d want 00400008 00100113 2", imem_addr, ifid_instr_o, fetch_count_o); end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_pc_o !== 32'h0040_0008 || ifid_instr_o !== mem[2] || fetch_count_o !== 32'd3) begin
      fails++; $display("FAIL stall_resume got %h %h %0d want 00400008 %h 3", ifid_pc_o, ifid_instr_o, fetch_count_o, mem[2]); end
  endtask

  task automatic test_redirect_over_stall;
    step(1'b0, 1'b1, 1'b1, 32'h0040_0040);
    tests++; if (imem_addr !== 32'h0040_0040 || ifid_valid_o !== 1'b0 || ifid_instr_o !== NOP) begin
      fails++; $display("FAIL redir_stall got %h %b %h want 00400040 0 00000013", imem_addr, ifid_valid_o, ifid_instr_o); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h0040_0040 || ifid_instr_o !== mem[16]) begin
      fails++; $display("FAIL redir_target got %b %h %h want 1 00400040 %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, mem[16]); end
  endtask

  task automatic test_random;
    logic s, rd;
    logic [31:0] t;
    for (int i = 0; i < 300; i++) begin
      s  = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) == 0);
      t  = BASE + 32'd4 * $urandom_range(0, 511);
      step(1'b0, s, rd, t);
      tests++; if (imem_addr !== m_pc) begin fails++; $display("FAIL rand_addr cyc %0d got %h want %h", i, imem_addr, m_pc); end
      tests++; if (ifid_valid_o !== m_valid || ifid_instr_o !== m_instr) begin
        fails++; $display("FAIL rand_ifid cyc %0d got %b %h want %b %h", i, ifid_valid_o, ifid_instr_o, m_valid, m_instr); end
      if (m_valid) begin
        tests++; if (ifid_pc_o !== m_ifpc || ifid_pc4_o !== m_ifpc4) begin
          fails++; $display("FAIL rand_pc cyc %0d got %h %h want %h %h", i, ifid_pc_o, ifid_pc4_o, m_ifpc, m_ifpc4); end
      end
      tests++; if (fetch_count_o !== m_count || fault_o !== m_fault) begin
        fails++; $display("FAIL rand_cnt cyc %0d got %0d %b want %0d %b", i, fetch_count_o, fault_o, m_count, m_fault); end
    end
  endtask

  task automatic test_fault_misaligned;
    logic [31:0] held_pc, held_cnt;
    held_pc = m_pc; held_cnt = m_count;
    step(1'b0, 1'b0, 1'b1, 32'h0040_0042);
    tests++; if (fault_o !== 1'b1 || fault_pc_o !== 32'h0040_0042 || imem_addr !== held_pc || ifid_valid_o !== 1'b0) begin
      fails++; $display("FAIL misalign got %b %h %h %b want 1 00400042 %h 0", fault_o, fault_pc_o, imem_addr, ifid_valid_o, held_pc); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, (i != 1), BASE);
      tests++; if (fault_o !== 1'b1 || fault_pc_o !== 32'h0040_0042 || imem_addr !== held_pc || fetch_count_o !== held_cnt || ifid_instr_o !== NOP) begin
        fails++; $display("FAIL fault_frozen got %b %h %h %0d %h want 1 00400042 %h %0d 00000013", fault_o, fault_pc_o, imem_addr, fetch_count_o, ifid_instr_o, held_pc, held_cnt); end
    end
  endtask

  task automatic test_fault_below;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h003F_FFFC);
    tests++; if (fault_o !== 1'b1 || fault_pc_o !== 32'h003F_FFFC || imem_addr !== BASE) begin
      fails++; $display("FAIL below_base got %b %h %h want 1 003ffffc %h", fault_o, fault_pc_o, imem_addr, BASE); end
  endtask

  task automatic test_end_of_window;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0FFC);
    tests++; if (imem_addr !== 32'h0040_0FFC || fault_o !== 1'b0) begin fails++; $display("FAIL last_word_redir got %h %b want 00400ffc 0", imem_addr, fault_o); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== 32'h0040_0FFC || ifid_instr_o !== mem[1023]) begin
      fails++; $display("FAIL last_word_capture got %b %h %h want 1 00400ffc %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, mem[1023]); end
    tests++; if (fault_o !== 1'b1 || fault_pc_o !== 32'h0040_1000 || fetch_count_o !== 32'd1) begin
      fails++; $display("FAIL window_end got %b %h %0d want 1 00401000 1", fault_o, fault_pc_o, fetch_count_o); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_valid_o !== 1'b0 || fetch_count_o !== 32'd1 || fault_o !== 1'b1) begin
      fails++; $display("FAIL post_window got %b %0d %b want 0 1 1", ifid_valid_o, fetch_count_o, fault_o); end
  endtask

  task automatic test_reset_mid_stall;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    tests++; if (fetch_count_o !== 32'd2 || imem_addr !== 32'h0040_0008) begin fails++; $display("FAIL pre_rst got %0d %h want 2 00400008", fetch_count_o, imem_addr); end
    @(negedge clk); stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    test_reset("rst_mid_stall");
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++; if (ifid_valid_o !== 1'b0 || imem_addr !== BASE) begin fails++; $display("FAIL rst_boot got %b %h want 0 %h", ifid_valid_o, imem_addr, BASE); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    test_reset("reset");
    test_boot_fetch();
    test_stall();
    test_redirect_over_stall();
    test_random();
    test_fault_misaligned();
    test_reset("rst_in_fault");
    test_fault_below();
    test_reset("rst_after_below");
    test_end_of_window();
    test_reset("rst_after_end");
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
